// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HI
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int bps_cnt(input longint clk_fre, input longint bps);
        return int'(clk_fre / bps);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-FF synchroniser, falling-edge
// detect and a 3-point majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CNT_W = 9,
    parameter int HALF  = 217
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rxd,
    input  logic [CNT_W-1:0] i_clk_cnt,
    output logic             o_rxd_s,
    output logic             o_fall,
    output logic             o_bit_val
);

    localparam logic [CNT_W-1:0] C_PRE = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_MID = CNT_W'(HALF);

    logic r_sync1;
    logic r_sync2;
    logic r_vote0;
    logic r_vote1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            if (i_clk_cnt == C_PRE) r_vote0 <= r_sync2;
            if (i_clk_cnt == C_MID) r_vote1 <= r_sync2;
        end
    end

    // Third vote is the live synchronised line, so the decision is ready at HALF+1.
    assign o_rxd_s   = r_sync2;
    assign o_fall    = r_sync2 & ~r_sync1;
    assign o_bit_val = (r_vote0 & r_vote1) | (r_vote0 & r_sync2) | (r_vote1 & r_sync2);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, parity/stop checking and a one-entry
// valid/ready holding register feeding user logic.
//
//   state     | meaning
//   S_IDLE    | line idle, waiting for a synchronised falling edge
//   S_START   | validating the start bit at its centre
//   S_DATA    | shifting in DATA_BITS samples, LSB first
//   S_PARITY  | capturing the parity bit
//   S_STOP    | checking each stop bit; last good one completes the frame
//   S_WAIT_HI | after a bad stop bit, hold off until the line returns high
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BPS       = 9_600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det
);

    localparam int BPS_CNT = bps_cnt(CLK_FRE, BPS);
    localparam int HALF    = BPS_CNT >> 1;
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam int BIT_W   = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] C_DECIDE    = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(BPS_CNT - 1);
    localparam logic [BIT_W-1:0] C_DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] C_STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (BPS_CNT < 8) begin : g_bad_bps_cnt
        $error("uart_rx_param: CLK_FRE/BPS must be at least 8");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [CNT_W-1:0]     w_clk_cnt_nxt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [BIT_W-1:0]     w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun_err;
    logic                 r_break_det;

    logic w_rxd_s;
    logic w_fall;
    logic w_bit_val;
    logic w_at_decide;
    logic w_at_end;
    logic w_shift_en;
    logic w_par_en;
    logic w_complete;
    logic w_stop_fail;
    logic w_par_bad;
    logic w_break;
    logic w_load;

    uart_rx_sampler #(
        .CNT_W (CNT_W),
        .HALF  (HALF)
    ) u_sampler (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_rxd     (uart_rxd),
        .i_clk_cnt (r_clk_cnt),
        .o_rxd_s   (w_rxd_s),
        .o_fall    (w_fall),
        .o_bit_val (w_bit_val)
    );

    assign w_at_decide = (r_clk_cnt == C_DECIDE);
    assign w_at_end    = (r_clk_cnt == C_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = w_at_end ? '0 : r_clk_cnt + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_en    = 1'b0;
        w_par_en      = 1'b0;
        w_complete    = 1'b0;
        w_stop_fail   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
                if (w_fall) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_at_decide && w_bit_val) begin
                    w_state_nxt   = S_IDLE;
                    w_clk_cnt_nxt = '0;
                end else if (w_at_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_shift_en = w_at_decide;
                if (w_at_end) begin
                    if (r_bit_cnt == C_DATA_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                w_par_en = w_at_decide;
                if (w_at_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // Finishing at mid-stop leaves half a bit to catch an immediate start bit.
                if (w_at_decide) begin
                    if (!w_bit_val) begin
                        w_stop_fail   = 1'b1;
                        w_state_nxt   = S_WAIT_HI;
                        w_clk_cnt_nxt = '0;
                    end else if (r_bit_cnt == C_STOP_LAST) begin
                        w_complete    = 1'b1;
                        w_state_nxt   = S_IDLE;
                        w_clk_cnt_nxt = '0;
                    end
                end else if (w_at_end) begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_WAIT_HI: begin
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
                if (w_rxd_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

    // A break only counts when the very first stop bit is already low.
    assign w_par_bad = (PARITY != PAR_NONE) &&
                       (r_par_bit != (^r_shift ^ 1'(PARITY == PAR_ODD)));
    assign w_break   = (r_shift == '0) && ((PARITY == PAR_NONE) || !r_par_bit) &&
                       (r_bit_cnt == '0);
    assign w_load    = w_complete & ~w_par_bad & (~r_rx_valid | rx_ready);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= S_IDLE;
            r_clk_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_par_bit     <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_break_det   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_clk_cnt     <= w_clk_cnt_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            if (w_shift_en) r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
            if (w_par_en)   r_par_bit <= w_bit_val;
            r_parity_err  <= w_complete & w_par_bad;
            r_frame_err   <= w_stop_fail & ~w_break;
            r_break_det   <= w_stop_fail & w_break;
            r_overrun_err <= w_complete & ~w_par_bad & r_rx_valid & ~rx_ready;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign break_det   = r_break_det;

endmodule
